// File: rtl/yarp_pkg.sv
// Shared types and helpers for the YARP RV32I core.
// The LSU uses the access-size encoding and the alignment check defined here.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_t;

    localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

    // True for accesses that must complete with an error and never reach memory.
    function automatic logic lsu_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            HALF:          bad = addr_lo[0];
            WORD:          bad = (addr_lo != 2'b00);
            LSU_SIZE_RSVD: bad = 1'b1;
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Combinational byte-lane steering for the LSU: store side (byte enables,
// data replication, legality) and load side (lane extraction, sign/zero extension).
module yarp_lsu_align
    import yarp_pkg::*;
(
    input  logic [1:0]  req_addr_lo,
    input  logic [1:0]  req_size,
    input  logic [31:0] wr_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_zero_extnd,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data_rep,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        byte_en     = 4'b0000;
        wr_data_rep = wr_data;
        case (req_size)
            BYTE: begin
                byte_en     = 4'b0001 << req_addr_lo;
                wr_data_rep = {4{wr_data[7:0]}};
            end
            HALF: begin
                byte_en     = 4'b0011 << {req_addr_lo[1], 1'b0};
                wr_data_rep = {2{wr_data[15:0]}};
            end
            WORD: begin
                byte_en     = 4'b1111;
                wr_data_rep = wr_data;
            end
            default: begin
                byte_en     = 4'b0000;
                wr_data_rep = wr_data;
            end
        endcase
    end

    assign illegal = lsu_illegal(req_size, req_addr_lo);

    // Bring the addressed lane down to bit 0; words are always aligned so the shift is a no-op.
    assign shifted = rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_size)
            BYTE:    ld_data = {{24{~ld_zero_extnd & shifted[7]}}, shifted[7:0]};
            HALF:    ld_data = {{16{~ld_zero_extnd & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/yarp_lsu.sv
// Sequential load/store unit: one request/grant/response transaction per access,
// with a cycle budget that aborts a stalled access with an error.
module yarp_lsu
    import yarp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_zero_extnd_i,
    input  logic [31:0] lsu_wr_data_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rd_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    lsu_state_t  state;
    logic [1:0]  ld_addr_lo;
    logic [1:0]  ld_size;
    logic        ld_zero_extnd;
    logic [CW-1:0] tmo_cnt;

    logic        illegal;
    logic [3:0]  byte_en;
    logic [31:0] wr_data_rep;
    logic [31:0] ld_data;
    logic        timeout_hit;

    yarp_lsu_align u_align (
        .req_addr_lo   (lsu_addr_i[1:0]),
        .req_size      (lsu_size_i),
        .wr_data       (lsu_wr_data_i),
        .ld_addr_lo    (ld_addr_lo),
        .ld_size       (ld_size),
        .ld_zero_extnd (ld_zero_extnd),
        .rdata         (mem_rdata_i),
        .illegal       (illegal),
        .byte_en       (byte_en),
        .wr_data_rep   (wr_data_rep),
        .ld_data       (ld_data)
    );

    // The counter holds the cycles already spent in REQ/WAIT, so the current
    // cycle is the last one allowed when it reaches TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ld_addr_lo    <= 2'b00;
            ld_size       <= 2'b00;
            ld_zero_extnd <= 1'b0;
            tmo_cnt       <= '0;
            lsu_busy_o    <= 1'b0;
            lsu_done_o    <= 1'b0;
            lsu_err_o     <= 1'b0;
            lsu_rd_data_o <= 32'h0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= 32'h0;
            mem_wr_o      <= 1'b0;
            mem_byte_en_o <= 4'b0000;
            mem_wr_data_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    lsu_done_o <= 1'b0;
                    lsu_err_o  <= 1'b0;
                    tmo_cnt    <= '0;
                    if (lsu_req_i) begin
                        ld_addr_lo    <= lsu_addr_i[1:0];
                        ld_size       <= lsu_size_i;
                        ld_zero_extnd <= lsu_zero_extnd_i;
                        mem_addr_o    <= {lsu_addr_i[31:2], 2'b00};
                        mem_wr_o      <= lsu_wr_i;
                        mem_byte_en_o <= byte_en;
                        mem_wr_data_o <= wr_data_rep;
                        lsu_busy_o    <= 1'b1;
                        if (illegal) begin
                            state         <= DONE;
                            lsu_done_o    <= 1'b1;
                            lsu_err_o     <= 1'b1;
                            lsu_rd_data_o <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (timeout_hit) begin
                        mem_req_o     <= 1'b0;
                        state         <= DONE;
                        lsu_done_o    <= 1'b1;
                        lsu_err_o     <= 1'b1;
                        lsu_rd_data_o <= 32'h0;
                    end else if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (timeout_hit) begin
                        state         <= DONE;
                        lsu_done_o    <= 1'b1;
                        lsu_err_o     <= 1'b1;
                        lsu_rd_data_o <= 32'h0;
                    end else if (mem_rvalid_i) begin
                        state         <= DONE;
                        lsu_done_o    <= 1'b1;
                        lsu_err_o     <= 1'b0;
                        lsu_rd_data_o <= mem_wr_o ? 32'h0 : ld_data;
                    end
                end
                DONE: begin
                    lsu_done_o <= 1'b0;
                    lsu_err_o  <= 1'b0;
                    lsu_busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/yarp_lsu.md
Name: yarp_lsu

Overview:
Sequential load/store unit for the YARP RV32I core. It consumes the effective address produced by yarp_execute (alu_res_o) together with decoded load/store controls. It then runs a request/grant/response transaction on the data-memory port. The unit performs RV32I byte/half/word alignment, byte-lane steering and sign/zero extension, and returns the load result to writeback.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted with error; 0 disables the timeout.

Ports:
clk  input  1  core clock
reset  input  1  synchronous active-high reset
lsu_req_i  input  1  start access; sampled only in IDLE
lsu_addr_i  input  32  effective byte address (ALU result)
lsu_wr_i  input  1  1 = store, 0 = load
lsu_size_i  input  2  access size, lsu_size_t
lsu_zero_extnd_i  input  1  1 = zero-extend load (LBU/LHU)
lsu_wr_data_i  input  32  store data (rs2), low bytes significant
lsu_busy_o  output  1  high in every state other than IDLE
lsu_done_o  output  1  one-cycle completion pulse
lsu_err_o  output  1  valid with done: misaligned, reserved size or timeout
lsu_rd_data_o  output  32  extended load data; valid with done, held until the next done
mem_req_o  output  1  memory request, held until grant
mem_addr_o  output  32  word address, bits [1:0] = 0
mem_wr_o  output  1  store flag
mem_byte_en_o  output  4  byte-lane enables
mem_wr_data_o  output  32  lane-replicated store data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  response/ack (for loads and stores)
mem_rdata_i  input  32  read data, valid with rvalid

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0.
- A request is accepted when lsu_req_i=1 in IDLE. All request fields are registered on acceptance. Requests made while busy are ignored, not queued.
- Legality check on acceptance:
  - HALF with addr[0]=1 is misaligned.
  - WORD with addr[1:0]≠0 is misaligned.
  - size 2'b11 is reserved.
  - Any of these goes to DONE with err=1, rd_data=0, and no memory access.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE to REQ on a legal request.
  - REQ: mem_req_o=1 with stable addr/wr/byte_en/wr_data. On mem_gnt_i go to WAIT and drop mem_req_o the next cycle.
  - WAIT: on mem_rvalid_i, register the extracted load data and go to DONE.
  - DONE: lsu_done_o=1 for exactly one cycle, then IDLE.
- Minimum latency: accept at cycle 0, mem_req at cycle 1 (gnt the same cycle), rvalid at cycle 2, done at cycle 3. A misaligned access completes with done at cycle 1.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0].
  - HALF: 4'b0011<<{addr[1],1'b0}.
  - WORD: 4'b1111.
- Write data:
  - BYTE: {4{wd[7:0]}}.
  - HALF: {2{wd[15:0]}}.
  - WORD: wd.
- Load data: rdata>>(8*addr[1:0]), then bit 7 (BYTE) or bit 15 (HALF) is sign-extended unless zero_extnd=1. WORD is passed unchanged. Store completions drive rd_data=0.
- Timeout: the counter increments each cycle in REQ or WAIT. When it equals TIMEOUT_CYCLES, the unit drops mem_req_o and goes to DONE with err=1 and rd_data=0. The counter clears in IDLE.
- mem_gnt_i outside REQ is ignored; mem_rvalid_i outside WAIT is ignored, including a late response after a timeout or reset.
- A gnt and rvalid in the same cycle while in REQ: only the gnt counts; the response must come at least one cycle after the grant.
- Reset mid-transaction returns to IDLE immediately and the memory transaction is abandoned.

Decomposition:
- yarp_pkg gains lsu_size_t (BYTE=2'b00, HALF=2'b01, WORD=2'b10).
- The FSM state enum stays local to yarp_lsu.
- One combinational sub-module, yarp_lsu_align, holds the byte-enable, write-data replication and load extraction/extension logic. The FSM and timeout remain in yarp_lsu.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, done at cycle 3, rd_data 0xDEADBEEF, err 0.
- LB addr 0x103, rdata 0x80xxxxxx -> be 1000, rd_data 0xFFFFFF80; the same with LBU -> 0x00000080.
- SH addr 0x202, wd 0x1234ABCD -> be 1100, wr_data 0xABCDABCD, mem_wr 1, done after rvalid, rd_data 0.
- LW addr 0x101 -> no mem_req ever asserted, done+err at cycle 1; a request made while busy is ignored.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req held 4 cycles then dropped, done+err, a later rvalid ignored.
- Reset asserted in WAIT -> next cycle IDLE with all outputs 0; a subsequent rvalid causes no done.
